rd_unpack_fsm: RTL

//   Read-path counterpart of the UART->DDR byte packer. Takes 32-bit words read back from DDR

---
 rtl/ddr_uart_pkg.sv | 13 +
 rtl/rd_unpack_fsm_if.sv | 35 +++
 rtl/rd_unpack_fsm.sv | 75 +++++++
 3 files changed

// File: rtl/ddr_uart_pkg.sv
// Shared definitions for the DDR<->UART byte packer/unpacker pair.
// Defaults for word/byte widths and the two-state FSM encoding used by both paths.
package ddr_uart_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/rd_unpack_fsm_if.sv
// Word-in / byte-out handshake bundle for the DDR read-path unpacker.
// The slave modport is the unpacker's view; the master modport is the producer/FIFO side.
interface rd_unpack_fsm_if
    import ddr_uart_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BYTE_W = DEF_BYTE_W
);

    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [BYTE_W-1:0] fifo_din;

    modport slave (
        input  word_valid,
        input  word_data,
        input  fifo_full,
        output word_ready,
        output fifo_wr_en,
        output fifo_din
    );

    modport master (
        output word_valid,
        output word_data,
        output fifo_full,
        input  word_ready,
        input  fifo_wr_en,
        input  fifo_din
    );

endinterface

// File: rtl/rd_unpack_fsm.sv
// Serialises DDR read words into TX FIFO bytes, MSB first by default.
// Define RD_UNPACK_LSB_FIRST_EN to send byte 0 (LSB) first instead.
module rd_unpack_fsm
    import ddr_uart_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic               axi_clk,
    input  logic               rst,
    rd_unpack_fsm_if.slave     bus,
    output logic               busy,
    output logic               done
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    state_e            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              wr_en;

    assign wr_en          = (state_q == ST_SEND) && !bus.fifo_full;
    assign bus.fifo_wr_en = wr_en;
    assign bus.word_ready = (state_q == ST_IDLE);
    assign busy           = (state_q == ST_SEND);
    assign done           = done_q;

`ifdef RD_UNPACK_LSB_FIRST_EN
    assign bus.fifo_din = shreg_q[BYTE_W-1:0];
    assign shreg_d      = {{BYTE_W{1'b0}}, shreg_q[WORD_W-1:BYTE_W]};
`else
    assign bus.fifo_din = shreg_q[WORD_W-1 -: BYTE_W];
    assign shreg_d      = {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`endif

    // FSM, shift register and byte counter advance together on each accepted write
    always_ff @(posedge axi_clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.word_valid) begin
                        shreg_q <= bus.word_data;
                        cnt_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wr_en) begin
                        shreg_q <= shreg_d;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
